uart_multibyte_transmitter: RTL and testbench

Serial transmitter that sends fixed-length multi-byte messages over a UART line. It is the transmit-side counterpart of `uart_multibyte_receiver`: a message sent by this block and received by that block, with matching parameters, comes out unchanged on the receiver's `data` port. It sits between fabric logic that produces 32-bit status or readback words and the board `RsTx` pin, replacing the constant `RsTx = 0` tie-off.

---
 rtl/uart_multibyte_transmitter.sv | 136 +++++++++++++
 tb/tb_uart_multibyte_transmitter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_multibyte_transmitter.sv
// UART 8N1 transmitter for fixed-length multi-byte messages.
// Bytes go out most-significant first, each LSB-first, back to back with no gap.
module uart_multibyte_transmitter #(
  parameter int CLK_CYCLES    = 33,
  parameter int MSG_LOG_WIDTH = 2
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [8*(2**MSG_LOG_WIDTH)-1:0]     data,
  input  logic                                valid,
  output logic                                ready,
  output logic                                uart_tx
);

  localparam int N   = 2 ** MSG_LOG_WIDTH;
  localparam int W   = 8 * N;
  localparam int BW  = (CLK_CYCLES > 1) ? $clog2(CLK_CYCLES) : 1;
  // A single-byte message still needs a 1-bit byte counter to stay legal.
  localparam int BCW = (MSG_LOG_WIDTH > 0) ? MSG_LOG_WIDTH : 1;

  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_CYCLES - 1);
  localparam logic [BCW-1:0] BYTE_LAST = BCW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [BCW-1:0] byte_q, byte_d;
  logic [W-1:0]   msg_q, msg_d;
  logic           tx_q, tx_d;
  logic           baud_wrap;
  logic [7:0]     cur_byte_d;

  assign ready   = (state_q == ST_IDLE);
  assign uart_tx = tx_q;

  // State, counters, message register and line flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      msg_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      msg_q   <= msg_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic; the line level is derived from the next state so that
  // uart_tx comes straight from a flop and changes on the same edge as state.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    msg_d     = msg_q;
    baud_wrap = (baud_q == BAUD_LAST);

    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          state_d = ST_START;
          msg_d   = data;
          byte_d  = '0;
          baud_d  = '0;
          bit_d   = '0;
        end
      end

      ST_START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (byte_q == BYTE_LAST) begin
            state_d = ST_IDLE;
          end else begin
            byte_d  = byte_q + 1'b1;
            msg_d   = msg_q << 8;
            state_d = ST_START;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cur_byte_d = msg_d[W-1 -: 8];

    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = cur_byte_d[bit_d];
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_multibyte_transmitter.sv
// Self-checking bench for uart_multibyte_transmitter: a cycle-level line model
// predicts uart_tx/ready from accepted messages; a second small instance covers
// the minimum-baud, single-byte configuration.
module tb_uart_multibyte_transmitter;

  localparam int unsigned C   = 33;
  localparam int unsigned N   = 4;
  localparam int unsigned MSG = 10 * N * C;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  logic        uart_tx;

  logic [7:0]  data2;
  logic        valid2;
  logic        ready2;
  logic        tx2;

  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          mon_on = 1'b0;

  uart_multibyte_transmitter #(.CLK_CYCLES(33), .MSG_LOG_WIDTH(2)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .data    (data),
    .valid   (valid),
    .ready   (ready),
    .uart_tx (uart_tx)
  );

  uart_multibyte_transmitter #(.CLK_CYCLES(2), .MSG_LOG_WIDTH(0)) u_min (
    .clk     (clk),
    .reset_n (reset_n),
    .data    (data2),
    .valid   (valid2),
    .ready   (ready2),
    .uart_tx (tx2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Line level k cycles into a message, from the 8N1 frame rules.
  function automatic logic exp_line(input logic [31:0] msg, input int unsigned k);
    int unsigned bi  = k / (10 * C);
    int unsigned pos = (k % (10 * C)) / C;
    logic [7:0]  b   = 8'(msg >> (8 * (N - 1 - bi)));
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  // Reference model: message acceptance and busy window.
  bit          m_busy  = 1'b0;
  logic [31:0] m_msg   = '0;
  int unsigned m_cyc   = 0;
  int unsigned m_start = 0;
  int unsigned m_acc   = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (!m_busy) begin
        if (valid) begin
          m_busy  <= 1'b1;
          m_msg   <= data;
          m_start <= m_cyc + 1;
          m_acc   <= m_acc + 1;
        end
      end else if (m_cyc + 1 - m_start == MSG) begin
        m_busy <= 1'b0;
      end
    end
  end

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    if (mon_on) begin
      if (!reset_n) begin
        chk("rst_tx", uart_tx, 1);
        chk("rst_ready", ready, 1);
      end else if (m_busy) begin
        chk("tx", uart_tx, exp_line(m_msg, m_cyc - m_start));
        chk("ready_busy", ready, 0);
      end else begin
        chk("tx_idle", uart_tx, 1);
        chk("ready_idle", ready, 1);
      end
    end
  end

  task automatic wait_accept(input string tag);
    int unsigned a0 = m_acc;
    int unsigned n  = 0;
    while (m_acc == a0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 64'(m_acc != a0), 1);
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while (m_busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(m_busy), 0);
  endtask

  task automatic measure_busy(output int unsigned n);
    n = 0;
    while (ready == 1'b0 && n < 3000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse(input logic [31:0] w);
    @(negedge clk);
    data  = w;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    int unsigned n;
    int unsigned acc0;
    logic [31:0] w;
    logic [7:0]  b80;
    int unsigned pos;
    logic        e;

    reset_n = 1'b0;
    valid   = 1'b0;
    data    = '0;
    valid2  = 1'b0;
    data2   = '0;
    @(negedge clk);
    mon_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_tx", uart_tx, 1);
    chk("reset_ready", ready, 1);
    chk("reset_min_tx", tx2, 1);
    chk("reset_min_ready", ready2, 1);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single message with a one-cycle valid pulse.
    pulse(32'h0012_34AB);
    chk("msg1_accepted", m_acc, 1);
    measure_busy(n);
    chk("msg1_busy_len", n, MSG);
    wait_idle("msg1_idle");
    repeat (5) @(negedge clk);

    // Busy rejection: new word presented during byte 1 must be ignored.
    acc0 = m_acc;
    pulse($urandom);
    repeat (400) @(negedge clk);
    valid = 1'b1;
    data  = 32'hFFFF_FFFF;
    repeat (100) @(negedge clk);
    valid = 1'b0;
    data  = $urandom;
    wait_idle("busy_idle");
    repeat (50) @(negedge clk);
    chk("busy_not_sent", m_acc - acc0, 1);
    chk("busy_ready_back", ready, 1);
    pulse(32'hFFFF_FFFF);
    wait_idle("ffff_idle");
    repeat (5) @(negedge clk);

    // Back-to-back with valid held high.
    @(negedge clk);
    data  = 32'hA5A5_A5A5;
    valid = 1'b1;
    wait_accept("b2b_first_accept");
    @(negedge clk);
    data = 32'h5A5A_5A5A;
    measure_busy(n);
    chk("b2b_busy_len", n, MSG);
    @(negedge clk);
    chk("b2b_second_accept", ready, 0);
    valid = 1'b0;
    wait_idle("b2b_idle");
    repeat (5) @(negedge clk);

    // Reset during bit 4 of byte 2 (that bit forced to 0 so the jump is visible).
    w = $urandom & ~32'h0000_1000;
    pulse(w);
    repeat (840) @(negedge clk);
    chk("pre_reset_tx_low", uart_tx, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_tx", uart_tx, 1);
    chk("rst_async_ready", ready, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_ready", ready, 1);
    pulse(32'h0102_0304);
    wait_idle("post_reset_idle");
    repeat (5) @(negedge clk);

    // Randomized traffic: sparse random valid with random data every cycle.
    repeat (24000) begin
      @(negedge clk);
      valid = ($urandom_range(0, 7) == 0);
      data  = $urandom;
    end
    valid = 1'b0;
    wait_idle("random_idle");
    repeat (5) @(negedge clk);

    // Minimum baud, single-byte message 0x80.
    b80 = 8'h80;
    @(negedge clk);
    data2  = b80;
    valid2 = 1'b1;
    @(negedge clk);
    valid2 = 1'b0;
    data2  = 8'hFF;
    for (int unsigned k = 0; k < 20; k++) begin
      pos = k / 2;
      if (pos == 0)      e = 1'b0;
      else if (pos == 9) e = 1'b1;
      else               e = b80[pos-1];
      chk("min_tx", tx2, e);
      chk("min_ready", ready2, 0);
      @(negedge clk);
    end
    chk("min_end_ready", ready2, 1);
    chk("min_end_tx", tx2, 1);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
